// File: rtl/bit_stuff_if.sv
// Serial bit-stream link between the packet encoder, the bit stuffer and the NRZI stage.
// The master side is the encoder/NRZI environment; the slave side is the stuffer itself.
interface bit_stuff_if;
    logic       bstr_in;
    logic       bstr_in_ready;
    logic       stall;
    logic       bstr_out;
    logic       bstr_out_ready;
    logic [7:0] stuff_cnt;

    modport master (
        output bstr_in,
        output bstr_in_ready,
        input  stall,
        input  bstr_out,
        input  bstr_out_ready,
        input  stuff_cnt
    );

    modport slave (
        input  bstr_in,
        input  bstr_in_ready,
        output stall,
        output bstr_out,
        output bstr_out_ready,
        output stuff_cnt
    );
endinterface

// File: rtl/bit_stuff.sv
// USB-style bit stuffer: inserts a 0 after every run of six accepted 1s, with a
// one-cycle registered output and a registered stall while the zero is inserted.
module bit_stuff (
    input  logic        clk,
    input  logic        rst,
    bit_stuff_if.slave  bs
);

    typedef enum logic {
        ST_PASS,
        ST_STUFF
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  ones, ones_nx;
    logic        prev_rdy;
    logic        data_p1, data_nx;
    logic        vld_p1, vld_nx;
    logic [7:0]  cnt, cnt_nx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PASS;
            ones     <= 3'd0;
            prev_rdy <= 1'b0;
            data_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            state    <= state_nx;
            ones     <= ones_nx;
            prev_rdy <= bs.bstr_in_ready;
            data_p1  <= data_nx;
            vld_p1   <= vld_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ones_nx  = ones;
        data_nx  = 1'b0;
        vld_nx   = 1'b0;
        cnt_nx   = cnt;

        // The stuffed zero is emitted regardless of bstr_in_ready, so a packet
        // ending on a sixth 1 still gets its trailing zero.
        if (state == ST_STUFF) begin
            data_nx  = 1'b0;
            vld_nx   = 1'b1;
            ones_nx  = 3'd0;
            cnt_nx   = sat_inc(cnt);
            state_nx = ST_PASS;
        end else if (bs.bstr_in_ready) begin
            data_nx = bs.bstr_in;
            vld_nx  = 1'b1;
            if (!prev_rdy) begin
                cnt_nx = 8'd0;
            end
            if (bs.bstr_in) begin
                ones_nx = ones + 3'd1;
                if (ones == 3'd5) begin
                    state_nx = ST_STUFF;
                end
            end else begin
                ones_nx = 3'd0;
            end
        end else begin
            ones_nx = 3'd0;
        end
    end

    assign bs.stall          = (state == ST_STUFF);
    assign bs.bstr_out       = data_p1;
    assign bs.bstr_out_ready = vld_p1;
    assign bs.stuff_cnt      = cnt;

endmodule

// File: tb/tb_bit_stuff.sv
// Self-checking bench for bit_stuff: a packet-level stuffing model feeds an expected-bit
// queue that is checked every cycle, plus literal traces for the directed packets.
module tb_bit_stuff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_stuff_if bif ();

    bit_stuff dut (
        .clk (clk),
        .rst (rst),
        .bs  (bif)
    );

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    bit pkt[$];

    bit          log_en = 1'b0;
    logic [15:0] log_out, log_stall;
    int          log_n, log_first, log_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Per-cycle output check against the expected stuffed stream.
    always @(negedge clk) begin
        bit e;
        if (rst) begin
            chk("rst_bstr_out", bif.bstr_out, 0);
            chk("rst_bstr_out_ready", bif.bstr_out_ready, 0);
            chk("rst_stall", bif.stall, 0);
            chk("rst_stuff_cnt", bif.stuff_cnt, 0);
        end else if (bif.bstr_out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_bit", bif.bstr_out, e);
            end
        end else begin
            chk("idle_out_zero", bif.bstr_out, 0);
        end
        if (log_en) begin
            if (bif.bstr_out_ready) begin
                if (log_n == 0) log_first = log_idx;
                log_out   = {log_out[14:0], bif.bstr_out};
                log_stall = {log_stall[14:0], bif.stall};
                log_n++;
            end
            log_idx++;
        end
    end

    // Stuffed stream of a whole packet: a 0 follows every run of six 1s.
    task automatic model_push(input bit bits[$], output int stuffs);
        int run;
        run = 0;
        stuffs = 0;
        foreach (bits[i]) begin
            exp_q.push_back(bits[i]);
            run = bits[i] ? run + 1 : 0;
            if (run == 6) begin
                exp_q.push_back(1'b0);
                run = 0;
                stuffs++;
            end
        end
    endtask

    task automatic set_pkt(input logic [63:0] v, input int n);
        pkt.delete();
        for (int i = n - 1; i >= 0; i--) pkt.push_back(v[i]);
    endtask

    task automatic set_ones(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(1'b1);
    endtask

    task automatic log_start();
        log_out   = '0;
        log_stall = '0;
        log_n     = 0;
        log_first = -1;
        log_idx   = 0;
        log_en    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bif.bstr_in = 1'($urandom_range(0, 1));
        end
    endtask

    // Called at posedge+1. rst_at_stall>0 pulses reset on that stall cycle and abandons the packet.
    task automatic send_packet(input bit bits[$], input int rst_at_stall,
                               output int stalls, output int stuffs);
        int guard;
        model_push(bits, stuffs);
        stalls = 0;
        foreach (bits[i]) begin
            bif.bstr_in       = bits[i];
            bif.bstr_in_ready = 1'b1;
            guard = 0;
            while (bif.stall) begin
                stalls++;
                if (stalls == rst_at_stall) begin
                    rst = 1'b1;
                    bif.bstr_in_ready = 1'b0;
                    #1;
                    chk("rst_now_bstr_out", bif.bstr_out, 0);
                    chk("rst_now_bstr_out_ready", bif.bstr_out_ready, 0);
                    chk("rst_now_stall", bif.stall, 0);
                    chk("rst_now_stuff_cnt", bif.stuff_cnt, 0);
                    exp_q.delete();
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                guard++;
                if (guard > 3) begin
                    chk("stall_timeout", 1, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        if (bif.stall) stalls++;
        bif.bstr_in_ready = 1'b0;
        bif.bstr_in       = 1'($urandom_range(0, 1));
        idle(4);
    endtask

    task automatic end_checks(input string tag, input int stuffs, input int stalls);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_stuff_cnt"}, bif.stuff_cnt, (stuffs > 255) ? 255 : stuffs);
        chk({tag, "_stall_cycles"}, stalls, stuffs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, stuffs;
        rst = 1'b1;
        bif.bstr_in = 1'b1;
        bif.bstr_in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bstr_out", bif.bstr_out, 0);
        chk("reset_bstr_out_ready", bif.bstr_out_ready, 0);
        chk("reset_stall", bif.stall, 0);
        chk("reset_stuff_cnt", bif.stuff_cnt, 0);
        rst = 1'b0;
        idle(3);

        // Seven 1s: one stuffed zero after the sixth.
        set_pkt(64'b1111111, 7);
        log_start();
        send_packet(pkt, 0, stalls, stuffs);
        log_en = 1'b0;
        end_checks("ones7", stuffs, stalls);
        chk("ones7_cnt_lit", bif.stuff_cnt, 1);
        chk("ones7_stalls_lit", stalls, 1);
        chk("ones7_nvalid", log_n, 8);
        chk("ones7_out", log_out[7:0], 8'b11111101);
        chk("ones7_stall_trace", log_stall[7:0], 8'b00000100);
        chk("ones7_latency", log_first, 1);

        // Runs of five never trigger stuffing.
        set_pkt(64'b01111101111100, 14);
        log_start();
        send_packet(pkt, 0, stalls, stuffs);
        log_en = 1'b0;
        end_checks("runs5", stuffs, stalls);
        chk("runs5_cnt_lit", bif.stuff_cnt, 0);
        chk("runs5_nvalid", log_n, 14);
        chk("runs5_out", log_out[13:0], 14'b01111101111100);
        chk("runs5_stall_trace", log_stall[13:0], 14'd0);

        // Twelve 1s: the stuffed zero resets the run.
        set_ones(12);
        log_start();
        send_packet(pkt, 0, stalls, stuffs);
        log_en = 1'b0;
        end_checks("ones12", stuffs, stalls);
        chk("ones12_cnt_lit", bif.stuff_cnt, 2);
        chk("ones12_nvalid", log_n, 14);
        chk("ones12_out", log_out[13:0], 14'b11111101111110);
        chk("ones12_stall_trace", log_stall[13:0], 14'b00000100000010);

        // Packet ends on a sixth 1: trailing zero after ready drops.
        set_pkt(64'b0111111, 7);
        log_start();
        send_packet(pkt, 0, stalls, stuffs);
        log_en = 1'b0;
        end_checks("tail", stuffs, stalls);
        chk("tail_cnt_lit", bif.stuff_cnt, 1);
        chk("tail_nvalid", log_n, 8);
        chk("tail_out", log_out[7:0], 8'b01111110);
        chk("tail_stall_trace", log_stall[7:0], 8'b00000010);

        // Reset on the second stall cycle, then a clean packet.
        set_ones(13);
        send_packet(pkt, 2, stalls, stuffs);
        chk("rstpkt_flushed_cnt", bif.stuff_cnt, 0);
        idle(2);
        set_pkt(64'b0111, 4);
        log_start();
        send_packet(pkt, 0, stalls, stuffs);
        log_en = 1'b0;
        end_checks("after_rst", stuffs, stalls);
        chk("after_rst_cnt_lit", bif.stuff_cnt, 0);
        chk("after_rst_nvalid", log_n, 4);
        chk("after_rst_out", log_out[3:0], 4'b0111);

        // 1536 ones = 256 stuffs: counter saturates and holds.
        set_ones(1536);
        send_packet(pkt, 0, stalls, stuffs);
        end_checks("sat", stuffs, stalls);
        chk("sat_cnt_lit", bif.stuff_cnt, 255);
        chk("sat_stalls_lit", stalls, 256);
        idle(5);
        chk("sat_cnt_hold", bif.stuff_cnt, 255);

        // A new packet clears the counter.
        set_pkt(64'b0, 1);
        send_packet(pkt, 0, stalls, stuffs);
        end_checks("clear", stuffs, stalls);
        chk("clear_cnt_lit", bif.stuff_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
